// File: rtl/axi_rd_stream_ctrl.sv
// axi_rd_stream_ctrl: read-DMA sequencer that fetches a buffer over AXI4 AR/R and emits it as one AXI-Stream packet
module axi_rd_stream_ctrl #(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 64,
  parameter int ID_WIDTH        = 4,
  parameter int LEN_WIDTH       = 24,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    ap_start,
  output logic                    ap_done,
  input  logic [ADDR_WIDTH-1:0]   cfg_addr,
  input  logic [LEN_WIDTH-1:0]    cfg_beats,
  output logic                    err,
  output logic [ID_WIDTH-1:0]     m_axi_arid,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [7:0]              m_axi_arlen,
  output logic [2:0]              m_axi_arsize,
  output logic [1:0]              m_axi_arburst,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rlast,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready,
  output logic                    m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready
);
  localparam int BSH = $clog2(DATA_WIDTH / 8);
  localparam int OW  = $clog2(MAX_OUTSTANDING + 1);
  localparam int CW  = LEN_WIDTH > 13 ? LEN_WIDTH : 13;
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2;
  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] addr;
  logic [LEN_WIDTH-1:0]  rem_ar, rem_r;
  logic [OW-1:0]         outstanding, out_nx;
  logic [12:0]           pg_beats;
  logic [CW-1:0]         len_a, len;
  logic                  run, ar_hs, r_hs, r_fin, ar_load;
  assign run      = state == RUN;
  assign ar_hs    = m_axi_arvalid & m_axi_arready;
  assign r_hs     = m_axi_rvalid & m_axi_rready;
  assign r_fin    = r_hs & m_axi_rlast;
  assign pg_beats = (13'd4096 - {1'b0, addr[11:0]}) >> BSH;
  assign len_a    = CW'(rem_ar) < CW'(MAX_BURST) ? CW'(rem_ar) : CW'(MAX_BURST);
  assign len      = CW'(pg_beats) < len_a ? CW'(pg_beats) : len_a;
  assign out_nx   = outstanding + OW'(ar_hs) - OW'(r_fin);
  // addr/rem_ar track the next unpresented burst, so a new AR is loaded the edge the previous one handshakes
  assign ar_load  = run & (~m_axi_arvalid | m_axi_arready) & (rem_ar != '0) & (out_nx < OW'(MAX_OUTSTANDING));
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      addr          <= '0;
      rem_ar        <= '0;
      rem_r         <= '0;
      outstanding   <= '0;
      m_axi_arvalid <= 1'b0;
      m_axi_araddr  <= '0;
      m_axi_arlen   <= '0;
      err           <= 1'b0;
    end else begin
      m_axi_arvalid <= ar_load | (m_axi_arvalid & ~m_axi_arready);
      outstanding   <= out_nx;
      if (ar_load) begin
        m_axi_araddr <= addr;
        m_axi_arlen  <= 8'(len - CW'(1));
        addr         <= addr + (ADDR_WIDTH'(len) << BSH);
        rem_ar       <= rem_ar - LEN_WIDTH'(len);
      end
      if (r_hs) begin
        rem_r <= rem_r - LEN_WIDTH'(1);
        if (m_axi_rresp != 2'b00) err <= 1'b1;
      end
      if (state == IDLE && ap_start) begin
        state <= cfg_beats != '0 ? RUN : DONE;
        if (cfg_beats != '0) begin
          addr   <= cfg_addr;
          rem_ar <= cfg_beats;
          rem_r  <= cfg_beats;
          err    <= 1'b0;
        end
      end else if (run && r_hs && rem_r == LEN_WIDTH'(1)) begin
        state <= DONE;
      end else if (state == DONE) begin
        state <= IDLE;
      end
    end
  end
  assign ap_done       = state == DONE;
  assign m_axi_arid    = '0;
  assign m_axi_arsize  = 3'(BSH);
  assign m_axi_arburst = 2'b01;
  assign m_axi_rready  = m_axis_tready & run;
  assign m_axis_tvalid = m_axi_rvalid & run;
  assign m_axis_tdata  = m_axi_rdata;
  assign m_axis_tkeep  = '1;
  assign m_axis_tlast  = run & (rem_r == LEN_WIDTH'(1));
endmodule
